game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Top-level controller for the falling-bar dodge game.
- Sequences the bar datapath: start countdown, paced bar stepping, bar reload with a new hole position, hit/miss judging, lives, difficulty ramp and game over.
- Sits between the board inputs and the bar/score datapath. It issues single-cycle strobes only; it never holds bar position itself.

Parameters:
- START_PERIOD, 7, ticks per bar step at level 0.
- MIN_PERIOD, 1, fastest step period; the ramp stops here.
- ROUNDS_PER_LEVEL, 3, judged rounds before the period decrements.
- LIVES_INIT, 3, lives loaded at reset and at game start (range 1..3).
- HOLE_MAX, 13, largest legal hole_sel value.
- COUNTDOWN_TICKS, 3, ticks between start and the first bar.
- FLASH_TICKS, 4, ticks the bar freezes after a miss.

Ports:
- clk  in  1  system clock.
- clr_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle game-rate enable.
- start  in  1  start button, synchronised level; rising edge detected internally.
- bar_at_player  in  1  one-cycle pulse when the bar reaches the player row.
- player_in_hole  in  1  player aligned with the hole, sampled with bar_at_player.
- bar_offscreen  in  1  one-cycle pulse when the bar leaves the screen.
- bar_step  out  1  one-cycle advance strobe to the bar datapath.
- bar_reload  out  1  one-cycle strobe: move bar to top, latch hole_sel.
- hole_sel  out  4  hole position for the next bar, 0..HOLE_MAX.
- lives  out  2  remaining lives.
- level  out  3  difficulty level, saturating at 7.
- score_en  out  1  score timer enable.
- flash  out  1  miss indication.
- game_over  out  1  high in the OVER state.

Behaviour:
- Reset (clr_n low, async):
  - state=IDLE.
  - lives=LIVES_INIT, level=0, period=START_PERIOD.
  - Divider, round and countdown counters = 0.
  - LFSR=8'hA5.
  - All strobes 0, hole_sel=0, flash=0, score_en=0, game_over=0.
- Reset mid-game aborts immediately. No strobe is emitted on release.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clk cycle outside reset.
- Candidate hole: v=lfsr[3:0]. If v<=HOLE_MAX use v, else v-(HOLE_MAX+1).
- All outputs are registered. Strobe latency is one clk after the causing input.
- FSM states: IDLE, COUNTDOWN, PLAY, FLASH, OVER.
- IDLE:
  - Outputs quiet.
  - start rising edge: go to COUNTDOWN, clear countdown counter.
- COUNTDOWN:
  - Counts ticks.
  - On the COUNTDOWN_TICKS-th tick: latch candidate into hole_sel, pulse bar_reload, go to PLAY, clear divider.
- PLAY:
  - score_en=1.
  - Each tick increments the divider. When divider==period-1: pulse bar_step, divider=0.
  - bar_at_player: rounds+1.
    - If !player_in_hole: lives-1. Go to FLASH if lives>0 after the decrement, else go to OVER.
    - If rounds reaches ROUNDS_PER_LEVEL: rounds=0. If period>MIN_PERIOD, also period-1 and level+1 (saturating).
  - bar_offscreen: latch candidate into hole_sel, pulse bar_reload.
  - start is ignored.
- FLASH:
  - flash=1, score_en=1, bar_step suppressed, divider held.
  - Returns to PLAY after FLASH_TICKS ticks.
  - bar_offscreen is still honoured (reload issued).
- OVER:
  - game_over=1, score_en=0, no strobes.
  - start rising edge: reload lives/level/period/counters to reset values (LFSR keeps running), go to COUNTDOWN.
- Simultaneous events:
  - tick completing a period together with bar_at_player: bar_step is still issued; the state change applies next cycle.
  - bar_at_player together with bar_offscreen: both processed in the same cycle.
  - Miss on the last life together with bar_offscreen: go to OVER, reload suppressed.
- Lives never underflow. bar_at_player outside PLAY is ignored.

Optional Feature:
- Macro GAME_PAUSE_EN.
- When defined:
  - Adds input pause (synchronised level); its rising edge is detected internally.
  - In PLAY or FLASH, a pause edge enters PAUSED. All counters are frozen, score_en=0, no strobes.
  - The next pause edge returns to the saved state.
  - Inputs bar_at_player/bar_offscreen are ignored while PAUSED.
- When undefined: no pause port, no PAUSED state, behaviour exactly as above.

Test Plan:
- Reset, start edge, 3 ticks → bar_reload exactly once on the 4th-cycle boundary. hole_sel = mapped LFSR value (≤13). score_en rises.
- PLAY at level 0, 21 ticks → exactly 3 bar_step pulses, each 1 cycle, spaced 7 ticks.
- 3 bar_at_player with player_in_hole=1 → lives stays 3, level=1, next step spacing 6 ticks. Repeat until period=1 → level stops at 6, spacing stays 1.
- bar_at_player with player_in_hole=0 at lives=3 → lives=2, flash high for 4 ticks, no bar_step during flash, then stepping resumes.
- Three misses → lives=0, game_over=1, score_en=0, no strobes. Start edge → lives=3, level=0, countdown restarts.
- clr_n low mid-PLAY, asynchronous to clk → all outputs 0/reset values within the same cycle. After release: state IDLE, no strobes until start.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: top-level controller for the falling-bar dodge game.
// It drives the bar/score datapath with registered single-cycle strobes:
// start countdown, paced bar stepping, bar reload with a fresh hole,
// hit/miss judging, lives, difficulty ramp and game over.
// Optional build macro: GAME_PAUSE_EN adds a pause input and a PAUSED state.
module game_sequencer #(
    parameter int START_PERIOD     = 7,
    parameter int MIN_PERIOD       = 1,
    parameter int ROUNDS_PER_LEVEL = 3,
    parameter int LIVES_INIT       = 3,
    parameter int HOLE_MAX         = 13,
    parameter int COUNTDOWN_TICKS  = 3,
    parameter int FLASH_TICKS      = 4
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       tick,
    input  logic       start,
`ifdef GAME_PAUSE_EN
    input  logic       pause,
`endif
    input  logic       bar_at_player,
    input  logic       player_in_hole,
    input  logic       bar_offscreen,
    output logic       bar_step,
    output logic       bar_reload,
    output logic [3:0] hole_sel,
    output logic [1:0] lives,
    output logic [2:0] level,
    output logic       score_en,
    output logic       flash,
    output logic       game_over
);

    localparam int PW = $clog2(START_PERIOD + 1);
    localparam int RW = $clog2(ROUNDS_PER_LEVEL + 1);
    localparam int CW = $clog2(COUNTDOWN_TICKS + 1);
    localparam int FW = $clog2(FLASH_TICKS + 1);

    localparam logic [PW-1:0] START_P  = PW'(START_PERIOD);
    localparam logic [PW-1:0] MIN_P    = PW'(MIN_PERIOD);
    localparam logic [RW-1:0] ROUNDS_L = RW'(ROUNDS_PER_LEVEL);
    localparam logic [CW-1:0] CD_LAST  = CW'(COUNTDOWN_TICKS - 1);
    localparam logic [FW-1:0] FL_LAST  = FW'(FLASH_TICKS - 1);
    localparam logic [1:0]    LIVES_0  = 2'(LIVES_INIT);
    localparam logic [3:0]    HOLE_M   = 4'(HOLE_MAX);
    localparam logic [3:0]    HOLE_SUB = 4'(HOLE_MAX + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_COUNTDOWN = 3'd1;
    localparam logic [2:0] S_PLAY      = 3'd2;
    localparam logic [2:0] S_FLASH     = 3'd3;
    localparam logic [2:0] S_OVER      = 3'd4;
`ifdef GAME_PAUSE_EN
    localparam logic [2:0] S_PAUSED    = 3'd5;
`endif

    // Fold the 4-bit LFSR slice into the legal hole range 0..HOLE_MAX.
    function automatic logic [3:0] map_hole(input logic [3:0] v);
        if (v <= HOLE_M) begin
            map_hole = v;
        end else begin
            map_hole = v - HOLE_SUB;
        end
    endfunction

    // Fibonacci feedback for taps 8,6,5,4 (bit indices 7,5,4,3).
    function automatic logic lfsr_fb(input logic [7:0] s);
        lfsr_fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    endfunction

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] period_q, period_d, div_q, div_d;
    logic [RW-1:0] rounds_q, rounds_d, rounds_nx;
    logic [CW-1:0] cd_q, cd_d;
    logic [FW-1:0] fl_q, fl_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic          start_prev_q;
    logic          start_rise;
    logic [1:0]    lives_q, lives_d, lives_nx;
    logic [2:0]    level_q, level_d;
    logic [3:0]    hole_q, hole_d, cand;
    logic          bar_step_q, bar_step_d, bar_reload_q, bar_reload_d;
    logic          score_en_q, score_en_d, flash_q, flash_d, game_over_q, game_over_d;
`ifdef GAME_PAUSE_EN
    logic          pause_prev_q;
    logic          pause_rise;
    logic [2:0]    saved_q, saved_d;
    assign pause_rise = pause & ~pause_prev_q;
`endif

    assign start_rise = start & ~start_prev_q;
    assign cand       = map_hole(lfsr_q[3:0]);

    // Next-state, counter and strobe computation for the whole sequencer.
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        div_d        = div_q;
        rounds_d     = rounds_q;
        rounds_nx    = rounds_q + RW'(1);
        cd_d         = cd_q;
        fl_d         = fl_q;
        lives_d      = lives_q;
        lives_nx     = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
        level_d      = level_q;
        hole_d       = hole_q;
        bar_step_d   = 1'b0;
        bar_reload_d = 1'b0;
        lfsr_d       = {lfsr_q[6:0], lfsr_fb(lfsr_q)};
`ifdef GAME_PAUSE_EN
        saved_d      = saved_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d = S_COUNTDOWN;
                    cd_d    = '0;
                end else begin
                    cd_d    = cd_q;
                end
            end
            S_COUNTDOWN: begin
                if (tick && (cd_q == CD_LAST)) begin
                    hole_d       = cand;
                    bar_reload_d = 1'b1;
                    state_d      = S_PLAY;
                    div_d        = '0;
                    cd_d         = '0;
                end else if (tick) begin
                    cd_d = cd_q + CW'(1);
                end else begin
                    cd_d = cd_q;
                end
            end
            S_PLAY: begin
`ifdef GAME_PAUSE_EN
                if (pause_rise) begin
                    saved_d = S_PLAY;
                    state_d = S_PAUSED;
                end else begin
`endif
                // A step completing together with a judge still goes out.
                if (tick && (div_q == period_q - PW'(1))) begin
                    bar_step_d = 1'b1;
                    div_d      = '0;
                end else if (tick) begin
                    div_d = div_q + PW'(1);
                end else begin
                    div_d = div_q;
                end
                if (bar_at_player) begin
                    if (rounds_nx == ROUNDS_L) begin
                        rounds_d = '0;
                        if (period_q > MIN_P) begin
                            period_d = period_q - PW'(1);
                            level_d  = (level_q == 3'd7) ? level_q : level_q + 3'd1;
                        end else begin
                            period_d = period_q;
                        end
                    end else begin
                        rounds_d = rounds_nx;
                    end
                    if (!player_in_hole) begin
                        lives_d = lives_nx;
                        if (lives_nx != 2'd0) begin
                            state_d = S_FLASH;
                            fl_d    = '0;
                        end else begin
                            state_d = S_OVER;
                        end
                    end else begin
                        lives_d = lives_q;
                    end
                end else begin
                    rounds_d = rounds_q;
                end
                // Losing the last life swallows a coincident reload.
                if (bar_offscreen && (state_d != S_OVER)) begin
                    hole_d       = cand;
                    bar_reload_d = 1'b1;
                end else begin
                    hole_d = hole_q;
                end
`ifdef GAME_PAUSE_EN
                end
`endif
            end
            S_FLASH: begin
`ifdef GAME_PAUSE_EN
                if (pause_rise) begin
                    saved_d = S_FLASH;
                    state_d = S_PAUSED;
                end else begin
`endif
                if (tick && (fl_q == FL_LAST)) begin
                    state_d = S_PLAY;
                    fl_d    = '0;
                end else if (tick) begin
                    fl_d = fl_q + FW'(1);
                end else begin
                    fl_d = fl_q;
                end
                if (bar_offscreen) begin
                    hole_d       = cand;
                    bar_reload_d = 1'b1;
                end else begin
                    hole_d = hole_q;
                end
`ifdef GAME_PAUSE_EN
                end
`endif
            end
            S_OVER: begin
                if (start_rise) begin
                    lives_d  = LIVES_0;
                    level_d  = 3'd0;
                    period_d = START_P;
                    div_d    = '0;
                    rounds_d = '0;
                    cd_d     = '0;
                    fl_d     = '0;
                    state_d  = S_COUNTDOWN;
                end else begin
                    state_d = S_OVER;
                end
            end
`ifdef GAME_PAUSE_EN
            S_PAUSED: begin
                if (pause_rise) begin
                    state_d = saved_q;
                end else begin
                    state_d = S_PAUSED;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
        score_en_d  = (state_d == S_PLAY) || (state_d == S_FLASH);
        flash_d     = (state_d == S_FLASH);
        game_over_d = (state_d == S_OVER);
    end

    // State, counters and registered outputs with asynchronous clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q      <= S_IDLE;
            period_q     <= START_P;
            div_q        <= '0;
            rounds_q     <= '0;
            cd_q         <= '0;
            fl_q         <= '0;
            lfsr_q       <= 8'hA5;
            start_prev_q <= 1'b0;
            lives_q      <= LIVES_0;
            level_q      <= 3'd0;
            hole_q       <= 4'd0;
            bar_step_q   <= 1'b0;
            bar_reload_q <= 1'b0;
            score_en_q   <= 1'b0;
            flash_q      <= 1'b0;
            game_over_q  <= 1'b0;
`ifdef GAME_PAUSE_EN
            pause_prev_q <= 1'b0;
            saved_q      <= S_IDLE;
`endif
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            div_q        <= div_d;
            rounds_q     <= rounds_d;
            cd_q         <= cd_d;
            fl_q         <= fl_d;
            lfsr_q       <= lfsr_d;
            start_prev_q <= start;
            lives_q      <= lives_d;
            level_q      <= level_d;
            hole_q       <= hole_d;
            bar_step_q   <= bar_step_d;
            bar_reload_q <= bar_reload_d;
            score_en_q   <= score_en_d;
            flash_q      <= flash_d;
            game_over_q  <= game_over_d;
`ifdef GAME_PAUSE_EN
            pause_prev_q <= pause;
            saved_q      <= saved_d;
`endif
        end
    end

    assign bar_step   = bar_step_q;
    assign bar_reload = bar_reload_q;
    assign hole_sel   = hole_q;
    assign lives      = lives_q;
    assign level      = level_q;
    assign score_en   = score_en_q;
    assign flash      = flash_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer (default build).
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       bar_at_player = 1'b0;
    logic       player_in_hole = 1'b0;
    logic       bar_offscreen = 1'b0;
    logic       bar_step, bar_reload, score_en, flash, game_over;
    logic [3:0] hole_sel;
    logic [1:0] lives;
    logic [2:0] level;

    game_sequencer dut (
        .clk(clk), .clr_n(clr_n), .tick(tick), .start(start),
`ifdef GAME_PAUSE_EN
        .pause(pause),
`endif
        .bar_at_player(bar_at_player), .player_in_hole(player_in_hole),
        .bar_offscreen(bar_offscreen), .bar_step(bar_step), .bar_reload(bar_reload),
        .hole_sel(hole_sel), .lives(lives), .level(level), .score_en(score_en),
        .flash(flash), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Reference LFSR and the hole candidate seen just before each rising edge.
    logic [7:0] m_lfsr;
    logic [3:0] cand_edge = 4'd0;
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
    always @(posedge clk) begin
        cand_edge <= (m_lfsr[3:0] > 4'd13) ? m_lfsr[3:0] - 4'd14 : m_lfsr[3:0];
    end

    // Strobe counters sampled mid-cycle.
    int step_cnt = 0;
    int reload_cnt = 0;
    always @(negedge clk) begin
        if (bar_step === 1'b1)   step_cnt   <= step_cnt + 1;
        if (bar_reload === 1'b1) reload_cnt <= reload_cnt + 1;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) clk1();
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) clk1();
        tick = 1'b0;
    endtask

    task automatic bap(input logic hit, input logic off);
        bar_at_player = 1'b1; player_in_hole = hit; bar_offscreen = off;
        clk1();
        bar_at_player = 1'b0; player_in_hole = 1'b0; bar_offscreen = 1'b0;
    endtask

    task automatic reload_chk(input string tag);
        check({tag, " reload"}, bar_reload, 1);
        check({tag, " hole"}, hole_sel, cand_edge);
        check({tag, " hole_range"}, (hole_sel <= 4'd13), 1);
    endtask

    task automatic reset_vals(input string tag);
        check({tag, " lives"}, lives, 3);
        check({tag, " level"}, level, 0);
        check({tag, " step"}, bar_step, 0);
        check({tag, " reload"}, bar_reload, 0);
        check({tag, " hole"}, hole_sel, 0);
        check({tag, " flash"}, flash, 0);
        check({tag, " score_en"}, score_en, 0);
        check({tag, " game_over"}, game_over, 0);
    endtask

    // Expect exactly one bar_step after n ticks, none before, one cycle wide.
    task automatic step_gap(input int n, input string tag);
        int c0;
        idle(1);
        c0 = step_cnt;
        ticks(n - 1);
        idle(1);
        check({tag, " quiet"}, step_cnt - c0, 0);
        ticks(1);
        check({tag, " step"}, bar_step, 1);
        idle(1);
        check({tag, " one_cycle"}, bar_step, 0);
        check({tag, " count"}, step_cnt - c0, 1);
    endtask

    initial begin
        int c0;
        int r0;
        #1 clr_n = 1'b0;
        #2 reset_vals("reset");
        #9 clr_n = 1'b1;
        idle(2);

        // Start and countdown.
        r0 = reload_cnt;
        start = 1'b1; clk1(); start = 1'b0;
        check("countdown score_en", score_en, 0);
        ticks(2);
        check("countdown early reload", bar_reload, 0);
        ticks(1);
        reload_chk("first_bar");
        check("first_bar score_en", score_en, 1);
        idle(1);
        check("first_bar reload_once", reload_cnt - r0, 1);

        // Level 0 pacing: 21 ticks give three steps.
        for (int i = 0; i < 3; i++) step_gap(7, "L0");

        // Difficulty ramp down to the minimum period.
        for (int lv = 1; lv <= 7; lv++) begin
            repeat (3) bap(1'b1, 1'b0);
            check("ramp level", level, (lv > 6) ? 6 : lv);
            check("ramp lives", lives, 3);
            step_gap((lv >= 6) ? 1 : 7 - lv, "ramp");
        end

        // Reload while playing.
        bar_offscreen = 1'b1; clk1(); bar_offscreen = 1'b0;
        reload_chk("off_play");

        // First miss: flash for four ticks, no stepping, reload still honoured.
        bap(1'b0, 1'b0);
        check("miss1 lives", lives, 2);
        check("miss1 flash", flash, 1);
        check("miss1 score_en", score_en, 1);
        c0 = step_cnt;
        ticks(3);
        check("flash held", flash, 1);
        bar_offscreen = 1'b1; clk1(); bar_offscreen = 1'b0;
        reload_chk("off_flash");
        ticks(1);
        check("flash end", flash, 0);
        idle(1);
        check("flash no_step", step_cnt - c0, 0);
        step_gap(1, "resume");

        // Second miss, then back to play.
        bap(1'b0, 1'b0);
        check("miss2 lives", lives, 1);
        ticks(4);
        check("miss2 flash end", flash, 0);

        // Last life lost together with offscreen: over, reload suppressed.
        r0 = reload_cnt;
        bap(1'b0, 1'b1);
        check("over lives", lives, 0);
        check("over game_over", game_over, 1);
        check("over score_en", score_en, 0);
        check("over reload", bar_reload, 0);
        c0 = step_cnt;
        ticks(10);
        bap(1'b0, 1'b1);
        idle(1);
        check("over no_step", step_cnt - c0, 0);
        check("over no_reload", reload_cnt - r0, 0);
        check("over lives_floor", lives, 0);

        // Restart from game over.
        start = 1'b1; clk1(); start = 1'b0;
        check("restart lives", lives, 3);
        check("restart level", level, 0);
        check("restart game_over", game_over, 0);
        ticks(3);
        reload_chk("restart_bar");
        step_gap(7, "restart");

        // Hit and offscreen in the same cycle: both handled.
        bap(1'b1, 1'b1);
        reload_chk("both");
        bap(1'b1, 1'b0);
        bap(1'b1, 1'b0);
        check("both level", level, 1);

        // Asynchronous clear mid-play.
        @(posedge clk);
        #3 clr_n = 1'b0;
        #1 reset_vals("async");
        #3 clr_n = 1'b1;
        c0 = step_cnt;
        r0 = reload_cnt;
        ticks(20);
        bap(1'b0, 1'b1);
        idle(1);
        check("post_reset no_step", step_cnt - c0, 0);
        check("post_reset no_reload", reload_cnt - r0, 0);
        check("post_reset score_en", score_en, 0);
        check("post_reset lives", lives, 3);
        start = 1'b1; clk1(); start = 1'b0;
        ticks(3);
        reload_chk("post_reset_bar");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
